// File: rtl/adder_share_sched.sv
// -----------------------------------------------------------------------------
// adder_share_sched
//   Round-robin scheduler that time-shares one external combinational
//   carry-lookahead adder among N_REQ requesters. The winner's operands are
//   registered into the adder, the sum is captured one cycle later, and it is
//   returned on a tagged valid/ready result channel.
//
// Parameters
//   N_REQ  number of requesters (>=1)
//   WIDTH  operand/sum width, equal to the shared adder's width
//   IDW    requester-id width (derived, min 1)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready is one-hot)
//   req_a/req_b/req_c_in    packed operands, requester i at [i*WIDTH +: WIDTH]
//   a, b, c_in              registered operands driving the shared adder
//   out, c_out              combinational result from the shared adder
//   rsp_valid/rsp_ready     result handshake
//   rsp_id/rsp_sum/rsp_c_out  tagged captured result
//
// Optional feature (macro ADD_SCHED_STATS_EN)
//   op_count  16-bit wrapping count of result handshakes
//   ovf_seen  sticky flag, set when a handed-off result had rsp_c_out=1
// -----------------------------------------------------------------------------
module adder_share_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_c_in,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output logic                   c_in,
  input  logic [WIDTH-1:0]       out,
  input  logic                   c_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_c_out
`ifdef ADD_SCHED_STATS_EN
  ,
  output logic [15:0]            op_count,
  output logic                   ovf_seen
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr;      // last winner; search starts just after it
  logic [IDW-1:0]  tag;         // id of the operation currently in the adder
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic            grant_found;
  logic            accept;

  // Cyclic search for the first valid requester after the last winner.
  // NOTE: every variable assigned in a combinational block gets a default
  // first, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? CALC : IDLE;
      CALC:    state_nxt = RESP;
      RESP:    if (accept)         state_nxt = CALC;
               else if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. A new operation is accepted while idle, or in the same
  // cycle the pending result is handed off. Gating with rst_n keeps the
  // grant low while reset is asserted even if requests are pending.
  always_comb begin
    accept    = rst_n && grant_found &&
                ((state == IDLE) || ((state == RESP) && rsp_ready));
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    rsp_valid = (state == RESP);
  end

  // Datapath. a/b/c_in change only on accept so the shared adder's inputs
  // stay quiet between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      c_in      <= 1'b0;
      tag       <= '0;
      rr_ptr    <= IDW'(N_REQ - 1);
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_c_out <= 1'b0;
    end else begin
      if (accept) begin
        a      <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        b      <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        c_in   <= req_c_in[grant_idx];
        tag    <= grant_idx;
        rr_ptr <= grant_idx;
      end
      if (state == CALC) begin
        rsp_sum   <= out;
        rsp_c_out <= c_out;
        rsp_id    <= tag;
      end
    end
  end

`ifdef ADD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
      ovf_seen <= 1'b0;
    end else if (rsp_valid && rsp_ready) begin
      op_count <= op_count + 16'd1;
      if (rsp_c_out) ovf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_share_sched
//   Self-checking bench for adder_share_sched (N_REQ=4, WIDTH=16). Models the
//   shared adder as plain arithmetic on the DUT's a/b/c_in, keeps a scoreboard
//   of expected results per granted request, and checks grants against the
//   round-robin rule. Directed vectors, multi-cycle corner sequences and a
//   random phase follow. Define ADD_SCHED_STATS_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_adder_share_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_c_in;
  logic [W-1:0]   a, b, out;
  logic           c_in, c_out;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_c_out;
`ifdef ADD_SCHED_STATS_EN
  logic [15:0]    op_count;
  logic           ovf_seen;
`endif

  always #5 clk = ~clk;

  // The shared adder lives outside the scheduler.
  assign {c_out, out} = 17'(a) + 17'(b) + 17'(c_in);

  adder_share_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c_in(req_c_in),
    .a(a), .b(b), .c_in(c_in), .out(out), .c_out(c_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out)
`ifdef ADD_SCHED_STATS_EN
    , .op_count(op_count), .ovf_seen(ovf_seen)
`endif
  );

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  typedef struct {
    int          id;
    logic [16:0] res;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   last_w;
  int   hs_count;
  bit   ovf_model;
  bit   hold;
  logic [15:0] h_sum;
  logic [1:0]  h_id;
  logic        h_cout;
  // Per-cycle observations published by cycle().
  bit   grant_seen, rsp_hs;
  int   grant_id;
  logic [15:0] s_sum;
  logic        s_cout;
  logic [1:0]  s_id;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester after the last winner.
  function automatic int rr_pick(input logic [N-1:0] v, input int lw);
    for (int k = 1; k <= N; k++)
      if (v[(lw + k) % N]) return (lw + k) % N;
    return -1;
  endfunction

  // Called at a falling edge after inputs are driven: observes the handshakes
  // that the next rising edge will commit, then advances to the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    cyc++;
    grant_seen = 0;
    rsp_hs     = 0;
    if (hold) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_sum", rsp_sum, h_sum);
      check("hold_id", rsp_id, h_id);
      check("hold_cout", rsp_c_out, h_cout);
    end
    if (req_ready != '0) begin
      grant_id = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_id = i;
      check("grant_onehot", $countones(req_ready), 1);
      check("grant_is_valid", ((req_ready & ~req_valid) == '0), 1);
      check("grant_rr", grant_id, rr_pick(req_valid, last_w));
      e.id  = grant_id;
      e.res = 17'(req_a[grant_id*W +: W]) + 17'(req_b[grant_id*W +: W]) + 17'(req_c_in[grant_id]);
      sb.push_back(e);
      last_w     = grant_id;
      grant_seen = 1;
    end
    if (rsp_valid && rsp_ready) begin
      rsp_hs = 1;
      s_sum  = rsp_sum;
      s_cout = rsp_c_out;
      s_id   = rsp_id;
      hs_count++;
      if (rsp_c_out) ovf_model = 1;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_sum", rsp_sum, e.res[15:0]);
        check("rsp_cout", rsp_c_out, e.res[16]);
      end
    end
    hold   = rsp_valid && !rsp_ready;
    h_sum  = rsp_sum;
    h_id   = rsp_id;
    h_cout = rsp_c_out;
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    last_w    = N - 1;
    hold      = 0;
    hs_count  = 0;
    ovf_model = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_a"}, a, 0);
    check({tag, "_b"}, b, 0);
    check({tag, "_c_in"}, c_in, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_sum"}, rsp_sum, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_c_out"}, rsp_c_out, 0);
  endtask

  // Single-requester vector: grant, 2-cycle latency, result against the table.
  task automatic run_vec(input vec_t v);
    bit got_g, got_r;
    int gc, rc;
    logic [15:0] r_sum;
    logic        r_cout;
    logic [1:0]  r_id;
    got_g = 0; got_r = 0; gc = 0; rc = 0; r_sum = '0; r_cout = 0; r_id = '0;
    req_valid           = '0;
    req_valid[v.id]     = 1'b1;
    req_a[v.id*W +: W]  = v.a;
    req_b[v.id*W +: W]  = v.b;
    req_c_in[v.id]      = v.cin;
    rsp_ready           = 1'b1;
    for (int n = 0; n < 12 && !got_r; n++) begin
      cycle();
      if (grant_seen && !got_g) begin
        got_g = 1; gc = cyc; req_valid = '0;
      end
      if (rsp_hs) begin
        got_r = 1; rc = cyc; r_sum = s_sum; r_cout = s_cout; r_id = s_id;
      end
    end
    check("vec_grant", got_g, 1);
    check("vec_rsp", got_r, 1);
    check("vec_latency", rc - gc, 2);
    check("vec_sum", r_sum, v.exp_sum);
    check("vec_cout", r_cout, v.exp_cout);
    check("vec_id", r_id, v.id);
    check("vec_a_held", a, v.a);
  endtask

  vec_t        vecs[9];
  int          gord[$];
  int          gcy[$];
  logic [16:0] rres[$];
  logic [16:0] exp3[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 16'd1,     16'd10,    1'b0, 16'd11,    1'b0};
    vecs[1] = '{2, 16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1};
    vecs[2] = '{1, 16'd15,    16'd31,    1'b0, 16'd46,    1'b0};
    vecs[3] = '{3, 16'd128,   16'd1478,  1'b0, 16'd1606,  1'b0};
    vecs[4] = '{2, 16'd94,    16'd333,   1'b0, 16'd427,   1'b0};
    vecs[5] = '{3, 16'd1,     16'd1,     1'b1, 16'd3,     1'b0};
    vecs[6] = '{1, 16'h8000,  16'h8000,  1'b1, 16'h0001,  1'b1};
    vecs[7] = '{0, 16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1};
    vecs[8] = '{2, 16'h0000,  16'h0000,  1'b0, 16'h0000,  1'b0};

    // Reset state, with requests pending while reset is held.
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c_in = '0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of CALC; requester 0 wins afterwards.
    req_valid = 4'b0010;
    req_a[1*W +: W] = 16'h1234; req_b[1*W +: W] = 16'h1111;
    cycle();
    check("pre_reset_grant", grant_seen ? grant_id : -1, 1);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '1; rsp_ready = 1'b1;
    cycle();
    check("post_reset_winner", grant_seen ? grant_id : -1, 0);
    req_valid = '0;
    for (int n = 0; n < 4; n++) cycle();

    // Table-driven single-requester vectors.
    do_reset();
    foreach (vecs[i]) run_vec(vecs[i]);

    // All four valid: grants in id order, two cycles apart.
    do_reset();
    req_a = {16'd1, 16'd94, 16'd128, 16'd15};
    req_b = {16'd1, 16'd333, 16'd1478, 16'd31};
    req_c_in = 4'b1000;
    exp3[0] = 17'd46; exp3[1] = 17'd1606; exp3[2] = 17'd427; exp3[3] = 17'd3;
    req_valid = '1; rsp_ready = 1'b1;
    for (int n = 0; n < 30 && rres.size() < 4; n++) begin
      cycle();
      if (grant_seen) begin
        gord.push_back(grant_id); gcy.push_back(cyc); req_valid[grant_id] = 1'b0;
      end
      if (rsp_hs) rres.push_back({s_cout, s_sum});
    end
    check("all4_grants", gord.size(), 4);
    check("all4_results", rres.size(), 4);
    for (int i = 0; i < 4 && i < gord.size() && i < rres.size(); i++) begin
      check("all4_order", gord[i], i);
      check("all4_sum", rres[i], exp3[i]);
      if (i > 0) check("all4_spacing", gcy[i] - gcy[i-1], 2);
    end

    // Back-pressure: result held, no grant, then same-cycle hand-off and accept.
    do_reset();
    req_a[0*W +: W] = 16'd5; req_b[0*W +: W] = 16'd6; req_c_in[0] = 1'b0;
    req_valid = 4'b0001;
    cycle();
    check("bp_first_grant", grant_seen ? grant_id : -1, 0);
    req_valid = 4'b0010;
    req_a[1*W +: W] = 16'd7; req_b[1*W +: W] = 16'd8; req_c_in[1] = 1'b1;
    cycle();
    check("bp_calc_no_grant", grant_seen, 0);
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("bp_stall_ready", req_ready, 0);
      check("bp_stall_valid", rsp_valid, 1);
      check("bp_stall_sum", rsp_sum, 11);
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_release_grant", grant_seen ? grant_id : -1, 1);
    check("bp_release_hs", rsp_hs, 1);
    req_valid = '0;
    for (int n = 0; n < 4; n++) cycle();
    check("bp_drained", sb.size(), 0);

    // Random traffic against the scoreboard.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = W'($urandom);
        req_b[i*W +: W] = W'($urandom);
        req_c_in[i]     = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    check("rand_drained", sb.size(), 0);
    check("rand_idle", rsp_valid, 0);
`ifdef ADD_SCHED_STATS_EN
    check("stats_op_count", op_count, 16'(hs_count));
    check("stats_ovf_seen", ovf_seen, ovf_model);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
